// File: rtl/pov_column_scheduler_if.sv
// Bus bundle between the column scheduler, the frame RAM read port and the strip serializer.
// The master side is the scheduler; the slave side is the RAM plus serializer.
interface pov_column_scheduler_if #(
    parameter int unsigned THETA_BITS   = 6,
    parameter int unsigned LED_IDX_BITS = 5,
    parameter int unsigned PIXEL_BITS   = 24
);
    localparam int unsigned ADDR_BITS = THETA_BITS + LED_IDX_BITS;

    logic                  mem_rd_en;
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [PIXEL_BITS-1:0] mem_rdata;
    logic                  pix_valid;
    logic [PIXEL_BITS-1:0] pix_data;
    logic                  pix_last;
    logic                  pix_ready;

    modport master (
        output mem_rd_en, mem_addr, pix_valid, pix_data, pix_last,
        input  mem_rdata, pix_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, pix_valid, pix_data, pix_last,
        output mem_rdata, pix_ready
    );
endinterface

// File: rtl/pov_column_scheduler.sv
// Streams one LED column from frame RAM to the strip serializer per theta change.
// A single pending slot buffers the newest column; older pending columns are dropped and counted.
module pov_column_scheduler #(
    parameter int unsigned THETA_BITS   = 6,
    parameter int unsigned LED_IDX_BITS = 5,
    parameter int unsigned LED_COUNT    = 32,
    parameter int unsigned PIXEL_BITS   = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [THETA_BITS-1:0] theta,
    input  logic                  enable,
    pov_column_scheduler_if.master bus,
    output logic                  col_start,
    output logic                  busy,
    output logic [7:0]            overrun_count
);
    localparam int unsigned ADDR_BITS = THETA_BITS + LED_IDX_BITS;
    localparam logic [LED_IDX_BITS-1:0] LAST_IDX = LED_IDX_BITS'(LED_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_LOAD = 2'd2,
        S_SEND = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [THETA_BITS-1:0]   theta_q, theta_d;
    logic [THETA_BITS-1:0]   pend_theta_q, pend_theta_d;
    logic                    pending_q, pending_d;
    logic [THETA_BITS-1:0]   col_theta_q, col_theta_d;
    logic [LED_IDX_BITS-1:0] led_idx_q, led_idx_d;
    logic [PIXEL_BITS-1:0]   pix_data_q, pix_data_d;
    logic                    pix_valid_q, pix_valid_d;
    logic                    pix_last_q, pix_last_d;
    logic                    mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_BITS-1:0]    mem_addr_q, mem_addr_d;
    logic                    col_start_q, col_start_d;
    logic                    busy_q, busy_d;
    logic [7:0]              overrun_q, overrun_d;
    logic                    change_c;
    logic                    start_col_c;

    // Next-state, pending-slot and registered-output logic.
    always_comb begin
        state_d      = state_q;
        theta_d      = theta;
        pend_theta_d = pend_theta_q;
        pending_d    = pending_q;
        col_theta_d  = col_theta_q;
        led_idx_d    = led_idx_q;
        pix_data_d   = pix_data_q;
        pix_valid_d  = pix_valid_q;
        pix_last_d   = pix_last_q;
        mem_rd_en_d  = 1'b0;
        mem_addr_d   = '0;
        col_start_d  = 1'b0;
        overrun_d    = overrun_q;
        start_col_c  = 1'b0;
        change_c     = (theta != theta_q);

        case (state_q)
            S_IDLE: begin
                if (pending_q && enable) begin
                    start_col_c = 1'b1;
                end
            end
            S_READ: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                pix_data_d  = bus.mem_rdata;
                pix_valid_d = 1'b1;
                pix_last_d  = (led_idx_q == LAST_IDX);
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (bus.pix_ready) begin
                    pix_valid_d = 1'b0;
                    if (led_idx_q != LAST_IDX) begin
                        led_idx_d   = led_idx_q + LED_IDX_BITS'(1);
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = {col_theta_q, led_idx_q + LED_IDX_BITS'(1)};
                        state_d     = S_READ;
                    end else if (pending_q && enable) begin
                        start_col_c = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Column launch: latch the pending theta so it stays frozen for the whole column.
        if (start_col_c) begin
            state_d     = S_READ;
            col_theta_d = pend_theta_q;
            led_idx_d   = '0;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = {pend_theta_q, {LED_IDX_BITS{1'b0}}};
            col_start_d = 1'b1;
        end

        // A change refills the slot; it only overruns if the old entry was not taken this cycle.
        if (change_c) begin
            pending_d    = 1'b1;
            pend_theta_d = theta;
            if (pending_q && !start_col_c && (overrun_q != 8'hFF)) begin
                overrun_d = overrun_q + 8'd1;
            end
        end else if (start_col_c) begin
            pending_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            theta_q      <= '0;
            pend_theta_q <= '0;
            pending_q    <= 1'b0;
            col_theta_q  <= '0;
            led_idx_q    <= '0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_last_q   <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            col_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= '0;
        end else begin
            state_q      <= state_d;
            theta_q      <= theta_d;
            pend_theta_q <= pend_theta_d;
            pending_q    <= pending_d;
            col_theta_q  <= col_theta_d;
            led_idx_q    <= led_idx_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            pix_last_q   <= pix_last_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_addr_q   <= mem_addr_d;
            col_start_q  <= col_start_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.mem_rd_en  = mem_rd_en_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_data   = pix_data_q;
    assign bus.pix_last   = pix_last_q;
    assign col_start      = col_start_q;
    assign busy           = busy_q;
    assign overrun_count  = overrun_q;
endmodule
